i2s_serf: RTL and testbench
===========================

Name:
i2s_serf

Overview:
- Serial I2S receiver that sits at the audio front end of the equalizer.
- Deserializes stereo I2S from the Bluetooth audio module into parallel left/right samples.
- Emits a one-clock vld strobe per complete stereo frame; the EQ queues use vld to write samples.
- I2S_sclk and I2S_ws are asynchronous to clk; they are synchronized and edge-detected in the system clock domain, so no second clock domain exists in the RTL.

Parameters:
- SMPL_W, 24, bits captured per channel, MSB first; bits beyond SMPL_W in a slot are ignored.
- SYNC_STG, 2, number of synchronizer flops on I2S_sclk, I2S_ws and I2S_data (minimum 2).

Ports:
- clk  input  1  system clock; all logic is clocked on its rising edge
- rst_n  input  1  asynchronous active-low reset
- I2S_sclk  input  1  I2S bit clock; asynchronous; frequency ≤ clk/8
- I2S_ws  input  1  word select; 0 = left, 1 = right; changes on falling I2S_sclk
- I2S_data  input  1  serial data; valid on rising I2S_sclk
- lft_chnnl  output  SMPL_W  last complete left sample, two's complement
- rght_chnnl  output  SMPL_W  last complete right sample, two's complement
- vld  output  1  one-clk pulse; lft_chnnl and rght_chnnl are updated in the same cycle

Behaviour:
- Synchronization: sclk, ws and data each pass through SYNC_STG flops. An extra flop on synced sclk gives sclk_rise = synced sclk high AND previous synced sclk low.
- Sampling: ws and data are sampled only in cycles where sclk_rise is true, using the synced values, which are aligned across all three signals.
- ws_prev holds the ws value from the previous sclk_rise. Reset value is 1.
- State machine states: SYNC, LFT_DLY, LFT, RGHT_DLY, RGHT. Reset state is SYNC.
- SYNC: wait for an sclk_rise with ws = 0 and ws_prev = 1. That sclk_rise is the one-bit I2S delay slot and carries no data. Go to LFT and clear bit_cnt.
- LFT: on each sclk_rise, shift data into shft_reg (MSB first) and increment bit_cnt. When bit_cnt reaches SMPL_W, latch shft_reg into lft_hold and go to RGHT_DLY.
- RGHT_DLY: on sclk_rise with ws = 1 and ws_prev = 0 (delay slot), go to RGHT and clear bit_cnt. Any other sclk_rise is a pad bit and is ignored.
- RGHT: shift the same way as LFT. In the cycle where the SMPL_W-th bit is shifted in, go to LFT_DLY. On the next clk edge:
  - load lft_chnnl from lft_hold and rght_chnnl from the completed shift register;
  - assert vld for exactly one clk.
- LFT_DLY: on sclk_rise with ws = 0 and ws_prev = 1, go to LFT. Pad bits are ignored.
- Loss of sync: if a ws transition is seen on an sclk_rise while in LFT or RGHT (short slot), discard the partial word, produce no vld, and go to SYNC. The next ws falling edge restarts capture.
- A ws transition seen in RGHT_DLY while ws is still 0 (i.e. ws rising before the left word finished) is impossible, because a short slot is already caught in LFT.
- Latency: vld rises 1 clk after the clk cycle in which sclk_rise for the last right bit is detected. That is SYNC_STG + 2 clks after the physical sclk edge.
- Between pulses: vld is 0 and the outputs hold their values.
- Reset values: lft_chnnl = 0, rght_chnnl = 0, vld = 0, shft_reg = 0, lft_hold = 0, bit_cnt = 0, state = SYNC, synchronizer flops = 0.
- Reset mid-frame: all state is cleared asynchronously. After release, the block waits for a fresh ws falling edge, so no partial frame can produce vld.
- Counters: bit_cnt is $clog2(SMPL_W+1) bits wide and never wraps; the state change occurs at SMPL_W.
- Slot widths: 24-bit and 32-bit slots are both supported, because pad bits are ignored until the next ws transition.

Test Plan:
- Nominal frame: sclk = clk/16, 32-bit slots, left = 24'hABCDEF, right = 24'h123456 -> exactly one vld pulse after the right word; lft_chnnl = ABCDEF, rght_chnnl = 123456.
- Mid-frame start: release reset with ws = 1 and right-channel bits already in flight -> no vld until the first complete left+right frame, which then yields its correct values.
- Back-to-back frames: send 3 frames with left = 000001, 7FFFFF, 800000 and right = FFFFFF, 000000, 555555 -> 3 vld pulses, each exactly 1 clk, spaced 64 sclk periods apart; outputs hold between pulses.
- Short slot: ws toggles after 10 left bits -> no vld for that frame; the block resyncs and the next full frame (left = 0F0F0F, right = F0F0F0) produces correct output.
- Reset mid-word: assert rst_n = 0 during bit 12 of the right word -> outputs are 0 and vld = 0 immediately; after release, the first vld comes only from the next full frame.
- 24-bit slots: ws toggles immediately after 24 data bits plus the delay slot, left = 24'h800001, right = 24'h7FFFFE -> correct capture; no false loss-of-sync.

Source files
------------

// File: rtl/i2s_serf.sv
// I2S receiver: oversamples sclk/ws/data in the clk domain and delivers
// parallel left/right samples with a one-cycle vld strobe per stereo frame.
module i2s_serf #(
   parameter int SMPL_W   = 24,
   parameter int SYNC_STG = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              I2S_sclk,
   input  logic              I2S_ws,
   input  logic              I2S_data,
   output logic [SMPL_W-1:0] lft_chnnl,
   output logic [SMPL_W-1:0] rght_chnnl,
   output logic              vld
);

   localparam int CNT_W = $clog2(SMPL_W + 1);

   typedef enum logic [2:0] {SYNC, LFT_DLY, LFT, RGHT_DLY, RGHT} state_t;

   state_t              state_q, state_d;
   logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STG-1:0] ws_sync_q, ws_sync_d;
   logic [SYNC_STG-1:0] data_sync_q, data_sync_d;
   logic                sclk_prev_q, sclk_prev_d;
   logic                ws_prev_q, ws_prev_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [SMPL_W-1:0]   shft_reg_q, shft_reg_d;
   logic [SMPL_W-1:0]   lft_hold_q, lft_hold_d;
   logic [SMPL_W-1:0]   lft_chnnl_q, lft_chnnl_d;
   logic [SMPL_W-1:0]   rght_chnnl_q, rght_chnnl_d;
   logic                load_q, load_d;
   logic                vld_q, vld_d;

   logic                sclk_s, ws_s, data_s, sclk_rise, ws_fall, ws_rise;
   logic [CNT_W-1:0]    cnt_inc;
   logic [SMPL_W-1:0]   shft_next;

   assign sclk_s    = sclk_sync_q[SYNC_STG-1];
   assign ws_s      = ws_sync_q[SYNC_STG-1];
   assign data_s    = data_sync_q[SYNC_STG-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign ws_fall   = ~ws_s & ws_prev_q;
   assign ws_rise   = ws_s & ~ws_prev_q;
   assign cnt_inc   = bit_cnt_q + CNT_W'(1);
   assign shft_next = {shft_reg_q[SMPL_W-2:0], data_s};

   always_comb begin
      sclk_sync_d  = {sclk_sync_q[SYNC_STG-2:0], I2S_sclk};
      ws_sync_d    = {ws_sync_q[SYNC_STG-2:0], I2S_ws};
      data_sync_d  = {data_sync_q[SYNC_STG-2:0], I2S_data};
      sclk_prev_d  = sclk_s;
      state_d      = state_q;
      ws_prev_d    = ws_prev_q;
      bit_cnt_d    = bit_cnt_q;
      shft_reg_d   = shft_reg_q;
      lft_hold_d   = lft_hold_q;
      lft_chnnl_d  = lft_chnnl_q;
      rght_chnnl_d = rght_chnnl_q;
      load_d       = 1'b0;
      vld_d        = 1'b0;

      // Completed frame is published one clk after the last right bit lands.
      if (load_q) begin
         lft_chnnl_d  = lft_hold_q;
         rght_chnnl_d = shft_reg_q;
         vld_d        = 1'b1;
      end

      if (sclk_rise) begin
         ws_prev_d = ws_s;
         case (state_q)
            SYNC: begin
               if (ws_fall) begin
                  state_d   = LFT;
                  bit_cnt_d = '0;
               end
            end
            LFT, RGHT: begin
               // A ws edge inside a data word means the slot was short: drop it.
               if (ws_s != ws_prev_q) begin
                  state_d   = SYNC;
                  bit_cnt_d = '0;
               end else begin
                  shft_reg_d = shft_next;
                  bit_cnt_d  = cnt_inc;
                  if (cnt_inc == CNT_W'(SMPL_W)) begin
                     if (state_q == LFT) begin
                        lft_hold_d = shft_next;
                        state_d    = RGHT_DLY;
                     end else begin
                        load_d  = 1'b1;
                        state_d = LFT_DLY;
                     end
                  end
               end
            end
            RGHT_DLY: begin
               if (ws_rise) begin
                  state_d   = RGHT;
                  bit_cnt_d = '0;
               end
            end
            LFT_DLY: begin
               if (ws_fall) begin
                  state_d   = LFT;
                  bit_cnt_d = '0;
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SYNC;
         sclk_sync_q  <= '0;
         ws_sync_q    <= '0;
         data_sync_q  <= '0;
         sclk_prev_q  <= 1'b0;
         ws_prev_q    <= 1'b1;
         bit_cnt_q    <= '0;
         shft_reg_q   <= '0;
         lft_hold_q   <= '0;
         lft_chnnl_q  <= '0;
         rght_chnnl_q <= '0;
         load_q       <= 1'b0;
         vld_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sclk_sync_q  <= sclk_sync_d;
         ws_sync_q    <= ws_sync_d;
         data_sync_q  <= data_sync_d;
         sclk_prev_q  <= sclk_prev_d;
         ws_prev_q    <= ws_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shft_reg_q   <= shft_reg_d;
         lft_hold_q   <= lft_hold_d;
         lft_chnnl_q  <= lft_chnnl_d;
         rght_chnnl_q <= rght_chnnl_d;
         load_q       <= load_d;
         vld_q        <= vld_d;
      end
   end

   assign lft_chnnl  = lft_chnnl_q;
   assign rght_chnnl = rght_chnnl_q;
   assign vld        = vld_q;

endmodule

// File: tb/tb_i2s_serf.sv
// Bench for i2s_serf: drives I2S frames bit by bit and scores every vld
// pulse against a queue of expected stereo pairs.
module tb_i2s_serf;

   localparam int SMPL_W   = 24;
   localparam int SYNC_STG = 2;
   localparam int CLK_P    = 10;
   localparam int SCLK_H   = 80;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              I2S_sclk;
   logic              I2S_ws;
   logic              I2S_data;
   logic [SMPL_W-1:0] lft_chnnl;
   logic [SMPL_W-1:0] rght_chnnl;
   logic              vld;

   i2s_serf #(.SMPL_W(SMPL_W), .SYNC_STG(SYNC_STG)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .I2S_sclk   (I2S_sclk),
      .I2S_ws     (I2S_ws),
      .I2S_data   (I2S_data),
      .lft_chnnl  (lft_chnnl),
      .rght_chnnl (rght_chnnl),
      .vld        (vld)
   );

   initial forever #(CLK_P/2) clk = ~clk;

   int                n_assert = 0;
   int                n_fail   = 0;
   int                pulse_cnt = 0;
   int                exp_pulses = 0;
   logic [47:0]       exp_q[$];
   time               pulse_t[$];
   time               last_rbit_t = 0;
   logic [SMPL_W-1:0] exp_l = '0;
   logic [SMPL_W-1:0] exp_r = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every vld must match the oldest expected frame; outputs hold otherwise.
   initial begin
      logic        vld_last;
      logic [47:0] pair;
      time         lat;
      vld_last = 1'b0;
      forever begin
         @(negedge clk);
         if (vld === 1'b1) begin
            chk("vld_width", 64'(vld_last), 64'd0);
            chk("vld_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               pair  = exp_q.pop_front();
               exp_l = pair[47:24];
               exp_r = pair[23:0];
            end
            chk("lft_value", 64'(lft_chnnl), 64'(exp_l));
            chk("rght_value", 64'(rght_chnnl), 64'(exp_r));
            lat = $time - last_rbit_t;
            chk("latency", 64'(lat >= (SYNC_STG+1)*CLK_P && lat <= (SYNC_STG+3)*CLK_P), 64'd1);
            pulse_cnt++;
            pulse_t.push_back($time);
         end else begin
            chk("hold_l", 64'(lft_chnnl), 64'(exp_l));
            chk("hold_r", 64'(rght_chnnl), 64'(exp_r));
         end
         vld_last = vld;
      end
   end

   task automatic sclk_bit(input logic ws_v, input logic d_v);
      I2S_sclk = 1'b0;
      I2S_ws   = ws_v;
      I2S_data = d_v;
      #(SCLK_H);
      I2S_sclk = 1'b1;
      #(SCLK_H);
   endtask

   // Slot index 0 is the I2S delay bit, 1..SMPL_W carry data MSB first, the rest is padding.
   task automatic send_frame(input logic [SMPL_W-1:0] l, input logic [SMPL_W-1:0] r,
                             input int lslot, input int rslot, input int rst_at);
      logic d;
      if (lslot > SMPL_W && rslot > SMPL_W && rst_at < 0) begin
         exp_q.push_back({l, r});
         exp_pulses++;
      end
      for (int i = 0; i < lslot; i++) begin
         d = (i >= 1 && i <= SMPL_W) ? l[SMPL_W-i] : 1'($urandom);
         sclk_bit(1'b0, d);
      end
      for (int i = 0; i < rslot; i++) begin
         d = (i >= 1 && i <= SMPL_W) ? r[SMPL_W-i] : 1'($urandom);
         if (i == SMPL_W) last_rbit_t = $time + SCLK_H;
         if (i == rst_at) begin
            I2S_sclk = 1'b0;
            I2S_ws   = 1'b1;
            I2S_data = d;
            #40;
            rst_n = 1'b0;
            exp_l = '0;
            exp_r = '0;
            #1;
            chk("rst_mid_vld", 64'(vld), 64'd0);
            chk("rst_mid_lft", 64'(lft_chnnl), 64'd0);
            chk("rst_mid_rght", 64'(rght_chnnl), 64'd0);
            #20;
            rst_n = 1'b1;
            #19;
            I2S_sclk = 1'b1;
            #(SCLK_H);
         end else begin
            sclk_bit(1'b1, d);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      I2S_sclk = 1'b0;
      I2S_ws   = 1'b1;
      I2S_data = 1'b0;
      #33;
      chk("reset_vld", 64'(vld), 64'd0);
      chk("reset_lft", 64'(lft_chnnl), 64'd0);
      chk("reset_rght", 64'(rght_chnnl), 64'd0);
      rst_n = 1'b1;

      // Start in the middle of a right word, then a nominal 32-bit-slot frame.
      for (int i = 0; i < 15; i++) sclk_bit(1'b1, 1'($urandom));
      chk("midstart_no_vld", 64'(pulse_cnt), 64'd0);
      send_frame(24'hABCDEF, 24'h123456, 32, 32, -1);
      chk("nominal_cnt", 64'(pulse_cnt), 64'(exp_pulses));
      chk("nominal_lft", 64'(lft_chnnl), 64'h00ABCDEF);
      chk("nominal_rght", 64'(rght_chnnl), 64'h00123456);

      // Back-to-back frames, pulses 64 sclk periods apart.
      pulse_t.delete();
      send_frame(24'h000001, 24'hFFFFFF, 32, 32, -1);
      send_frame(24'h7FFFFF, 24'h000000, 32, 32, -1);
      send_frame(24'h800000, 24'h555555, 32, 32, -1);
      chk("b2b_cnt", 64'(pulse_cnt), 64'(exp_pulses));
      chk("b2b_npulse", 64'(pulse_t.size()), 64'd3);
      if (pulse_t.size() == 3) begin
         chk("b2b_gap1", 64'(pulse_t[1] - pulse_t[0]), 64'(64*2*SCLK_H));
         chk("b2b_gap2", 64'(pulse_t[2] - pulse_t[1]), 64'(64*2*SCLK_H));
      end

      // Short left slot (10 data bits) is dropped, next frame is captured.
      send_frame(24'($urandom), 24'($urandom), 11, 32, -1);
      chk("short_no_vld", 64'(pulse_cnt), 64'(exp_pulses));
      send_frame(24'h0F0F0F, 24'hF0F0F0, 32, 32, -1);
      chk("resync_cnt", 64'(pulse_cnt), 64'(exp_pulses));
      chk("resync_lft", 64'(lft_chnnl), 64'h000F0F0F);

      // Reset during bit 12 of the right word.
      send_frame(24'($urandom), 24'($urandom), 32, 32, 12);
      chk("rst_no_vld", 64'(pulse_cnt), 64'(exp_pulses));
      send_frame(24'($urandom), 24'($urandom), 32, 32, -1);
      chk("post_rst_cnt", 64'(pulse_cnt), 64'(exp_pulses));

      // Minimal 24-bit slots: ws toggles right after the last data bit.
      send_frame(24'h800001, 24'h7FFFFE, 25, 25, -1);
      send_frame(24'h800001, 24'h7FFFFE, 25, 25, -1);
      chk("slot24_cnt", 64'(pulse_cnt), 64'(exp_pulses));
      chk("slot24_rght", 64'(rght_chnnl), 64'h007FFFFE);

      // Random samples with random slot widths.
      for (int k = 0; k < 8; k++) begin
         send_frame(24'($urandom), 24'($urandom), int'($urandom_range(25, 32)),
                    int'($urandom_range(25, 32)), -1);
      end
      for (int i = 0; i < 4; i++) sclk_bit(1'b1, 1'b0);
      chk("final_cnt", 64'(pulse_cnt), 64'(exp_pulses));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
